// File: rtl/div_operand_queue.sv
// Buffered issue/retire stage around an external combinational divider.
// Operand pairs are queued in a small FIFO; the head pair drives the divider,
// and its quotient is captured into a registered result with its own
// valid/ready handshake. A zero divisor is trapped locally and reported
// through out_dbz with an all-ones quotient.
module div_operand_queue #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNTW      = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_b,
    output logic [DATAWIDTH-1:0] div_a,
    output logic [DATAWIDTH-1:0] div_b,
    input  logic [DATAWIDTH-1:0] div_quot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_quot,
    output logic                 out_dbz,
    output logic [CNTW-1:0]      count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    logic [DATAWIDTH-1:0] mem_a_q [DEPTH];
    logic [DATAWIDTH-1:0] mem_b_q [DEPTH];

    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CNTW-1:0]      count_q, count_d;
    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] quot_q, quot_d;
    logic                 dbz_q, dbz_d;

    logic                 push;
    logic                 load;
    logic                 not_empty;
    logic [DATAWIDTH-1:0] head_a;
    logic [DATAWIDTH-1:0] head_b;

    // Handshake qualifiers and divider drive, all from registered FIFO state.
    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q != CNTW'(DEPTH));
        push      = in_valid & in_ready;
        load      = not_empty & ((state_q == StEmpty) | out_ready);
        head_a    = mem_a_q[rptr_q];
        head_b    = mem_b_q[rptr_q];
        // An idle divider sees 0/1 so it never evaluates a divide-by-zero.
        div_a     = not_empty ? head_a : '0;
        div_b     = not_empty ? head_b : DATAWIDTH'(1);
    end

    // Pointer and occupancy next state; load and push may coincide.
    always_comb begin
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = load ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q + CNTW'(push) - CNTW'(load);
    end

    // Result stage next state: a load always wins over a plain drain.
    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull: begin
                if (load) begin
                    state_d = StFull;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (load) begin
            if (head_b == '0) begin
                quot_d = '1;
                dbz_d  = 1'b1;
            end else begin
                quot_d = div_quot;
                dbz_d  = 1'b0;
            end
        end
    end

    // Operand storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_a_q[wptr_q] <= in_a;
            mem_b_q[wptr_q] <= in_b;
        end
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= StEmpty;
            quot_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            quot_q  <= quot_d;
            dbz_q   <= dbz_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_quot  = quot_q;
    assign out_dbz   = dbz_q;
    assign count     = count_q;

endmodule

// File: tb/tb_div_operand_queue.sv
// Self-checking bench for div_operand_queue with a queue-based reference model.
module tb_div_operand_queue;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 3;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] div_a;
    logic [DW-1:0] div_b;
    logic [DW-1:0] div_quot;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_quot;
    logic          out_dbz;
    logic [CNTW-1:0] count;

    div_operand_queue #(
        .DATAWIDTH(DW),
        .DEPTH    (DEPTH),
        .CNTW     (CNTW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_quot (div_quot),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_quot (out_quot),
        .out_dbz  (out_dbz),
        .count    (count)
    );

    always #5 Clk = ~Clk;

    // Attached combinational divider.
    always_comb div_quot = (div_b != '0) ? div_a / div_b : '0;

    // Reference model: FIFO as queues, result register as three variables.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit            m_ov;
    logic [DW-1:0] m_quot;
    bit            m_dbz;

    logic [DW-1:0] got[$];
    bit            pushed;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_quot(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    // Compare every observable output against the model.
    task automatic check_all();
        chk("count", 32'(count), 32'(qa.size()));
        chk("in_ready", 32'(in_ready), 32'(qa.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_quot", 32'(out_quot), 32'(m_quot));
        chk("out_dbz", 32'(out_dbz), 32'(m_dbz));
        chk("div_a", 32'(div_a), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
        chk("div_b", 32'(div_b), (qb.size() != 0) ? 32'(qb[0]) : 32'd1);
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic tick();
        bit push, load;
        logic [DW-1:0] a, b;
        push = in_valid && (qa.size() != DEPTH);
        load = (qa.size() != 0) && (!m_ov || out_ready);
        if (out_valid && out_ready && !Rst) got.push_back(out_quot);
        @(posedge Clk);
        #1;
        pushed = 1'b0;
        if (Rst) begin
            qa.delete();
            qb.delete();
            m_ov   = 1'b0;
            m_quot = '0;
            m_dbz  = 1'b0;
        end else begin
            if (load) begin
                a = qa.pop_front();
                b = qb.pop_front();
                m_quot = ref_quot(a, b);
                m_dbz  = (b == '0);
                m_ov   = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (push) begin
                qa.push_back(in_a);
                qb.push_back(in_b);
                pushed = 1'b1;
            end
        end
        check_all();
    endtask

    logic [DW-1:0] bp_a[6] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    logic [DW-1:0] bp_b[6] = '{8'd2, 8'd4, 8'd5, 8'd8, 8'd5, 8'd6};
    logic [DW-1:0] bp_q[6] = '{8'd5, 8'd5, 8'd6, 8'd5, 8'd10, 8'd10};
    logic [DW-1:0] rnd_a[12];
    logic [DW-1:0] rnd_b[12];

    initial begin
        int idx;
        int cyc;

        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        m_ov = 1'b0; m_quot = '0; m_dbz = 1'b0;

        // Reset and idle
        tick(); tick();
        Rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_div_b", 32'(div_b), 32'd1);

        // Single op 100/7
        in_valid = 1'b1; in_a = 8'd100; in_b = 8'd7;
        tick();
        in_valid = 1'b0;
        chk("single_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_quot", 32'(out_quot), 32'd14);
        chk("model_single_quot", 32'(m_quot), 32'd14);
        tick();
        chk("single_drop", 32'(out_valid), 32'd0);

        // Divide by zero, then a normal op
        in_valid = 1'b1; in_a = 8'd55; in_b = 8'd0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("dbz_quot", 32'(out_quot), 32'hFF);
        chk("dbz_flag", 32'(out_dbz), 32'd1);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        chk("after_dbz_quot", 32'(out_quot), 32'd3);
        chk("after_dbz_flag", 32'(out_dbz), 32'd0);
        tick();

        // Backpressure and full
        got.delete();
        out_ready = 1'b0;
        idx = 0;
        cyc = 0;
        while (!(idx == 6 && got.size() == 6) && cyc < 60) begin
            if (cyc == 5) begin
                chk("bp_full_count", 32'(count), 32'd4);
                chk("bp_full_ready", 32'(in_ready), 32'd0);
                chk("bp_hold_quot", 32'(out_quot), 32'd5);
            end
            if (cyc == 9) chk("bp_stable_quot", 32'(out_quot), 32'd5);
            if (cyc >= 10) out_ready = 1'b1;
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_a = bp_a[idx];
                in_b = bp_b[idx];
            end
            tick();
            if (pushed) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_done_in_time", 32'(cyc < 60), 32'd1);
        chk("bp_result_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk("bp_order", 32'(got[i]), 32'(bp_q[i]));
        end
        tick();

        // Random stream with toggled handshakes
        got.delete();
        for (int i = 0; i < 12; i++) begin
            rnd_a[i] = DW'($urandom);
            rnd_b[i] = DW'($urandom_range(0, 15));
        end
        idx = 0;
        cyc = 0;
        while (!(idx == 12 && qa.size() == 0 && !m_ov) && cyc < 400) begin
            in_valid  = (idx < 12) && ($urandom_range(0, 2) != 0);
            out_ready = (cyc > 300) || ($urandom_range(0, 1) != 0);
            if (idx < 12) begin
                in_a = rnd_a[idx];
                in_b = rnd_b[idx];
            end else begin
                in_a = DW'($urandom);
                in_b = DW'($urandom);
            end
            tick();
            if (pushed) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rnd_done_in_time", 32'(cyc < 400), 32'd1);
        chk("rnd_result_count", 32'(got.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < got.size()) chk("rnd_order", 32'(got[i]), 32'(ref_quot(rnd_a[i], rnd_b[i])));
        end

        // Reset mid-operation: one held result plus three queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = DW'(8'd20 + 8'(i)); in_b = 8'd3;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
